// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS memory-stage constants, FSM encoding and access-size helpers
// Purpose : opcode constants for loads/stores, the M-stage FSM state type,
//           the access-size enum and small decode helpers used by mem_stage/mem_align.
// Ports   : none (package)
package mips_pkg;

  localparam int DW = 32;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  // SZ_NONE doubles as "not a memory op".
  function automatic acc_size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      OP_LW, OP_SW:         op_size = SZ_WORD;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    op_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                 (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane/byte-enable generation and load extract/extend
// Purpose : purely combinational big-endian lane handling (byte 0 = bits 31:24).
// Ports   : size, sign_ext, addr_lo (in)  - access size, extend mode, address[1:0]
//           st_data, ld_raw (in)          - rt store value, raw memory read word
//           be, wdata (out)               - byte enables and replicated store data
//           ld_data (out)                 - aligned, extended load result
module mem_align
  import mips_pkg::*;
(
  input  acc_size_e   size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = ld_raw[31:24];
    case (addr_lo)
      2'd1:    byte_v = ld_raw[23:16];
      2'd2:    byte_v = ld_raw[15:8];
      2'd3:    byte_v = ld_raw[7:0];
      default: byte_v = ld_raw[31:24];
    endcase
    half_v = addr_lo[1] ? ld_raw[15:0] : ld_raw[31:16];
  end

  always_comb begin
    be      = 4'b0000;
    wdata   = 32'h0;
    ld_data = 32'h0;
    case (size)
      SZ_BYTE: begin
        be      = 4'b1000 >> addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sign_ext & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = ld_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: X/M register, req/ack data-memory FSM, M/W register
// Purpose : holds the instruction leaving execute, performs aligned loads/stores on the
//           req/ack port, stalls upstream while an access is outstanding, drives writeback.
// Ports   : clock, reset (in)                     - clock, synchronous active-high reset
//           x_valid, x_o, x_b, x_insn, x_aluop,
//           x_dmwe, x_rwe, x_rdst, x_rwd (in)     - execute-stage outputs
//           stall (out)                           - upstream must hold this cycle
//           dm_req, dm_we, dm_addr, dm_be,
//           dm_wdata (out); dm_ack, dm_rdata (in) - data-memory port
//           w_o, w_d, w_insn, w_aluop, w_rwe,
//           w_rdst, w_rwd, w_misalign (out)       - M/W register to writeback
module mem_stage
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [31:0] x_o,
  input  logic [31:0] x_b,
  input  logic [31:0] x_insn,
  input  logic [5:0]  x_aluop,
  input  logic        x_dmwe,
  input  logic        x_rwe,
  input  logic        x_rdst,
  input  logic        x_rwd,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] w_o,
  output logic [31:0] w_d,
  output logic [31:0] w_insn,
  output logic [5:0]  w_aluop,
  output logic        w_rwe,
  output logic        w_rdst,
  output logic        w_rwd,
  output logic        w_misalign
);

  mem_state_e  state_q, state_d;

  logic [31:0] m_o_q, m_o_d, m_b_q, m_b_d, m_insn_q, m_insn_d;
  logic [5:0]  m_aluop_q, m_aluop_d;
  logic        m_dmwe_q, m_dmwe_d, m_rwe_q, m_rwe_d, m_rdst_q, m_rdst_d, m_rwd_q, m_rwd_d;

  logic [31:0] w_o_q, w_o_d, w_d_q, w_d_d, w_insn_q, w_insn_d;
  logic [5:0]  w_aluop_q, w_aluop_d;
  logic        w_rwe_q, w_rwe_d, w_rdst_q, w_rdst_d, w_rwd_q, w_rwd_d, w_mis_q, w_mis_d;

  logic [5:0]  m_op;
  acc_size_e   m_size;
  logic        m_aligned, m_issue, m_misalign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;

  assign m_op   = m_insn_q[31:26];
  assign m_size = op_size(m_op);

  always_comb begin
    m_aligned = 1'b1;
    if (m_size == SZ_HALF) m_aligned = ~m_o_q[0];
    if (m_size == SZ_WORD) m_aligned = (m_o_q[1:0] == 2'b00);
  end

  assign m_issue    = (m_size != SZ_NONE) &&  m_aligned;
  assign m_misalign = (m_size != SZ_NONE) && !m_aligned;

  mem_align u_align (
    .size     (m_size),
    .sign_ext (op_signed(m_op)),
    .addr_lo  (m_o_q[1:0]),
    .st_data  (m_b_q),
    .ld_raw   (dm_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld)
  );

  // M is frozen while waiting, so the request fields stay stable in WAIT
  // simply by being decoded from M.
  always_comb begin
    state_d = state_q;
    dm_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_issue) begin
          dm_req = 1'b1;
          if (!dm_ack) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dm_req = 1'b1;
        if (dm_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall    = dm_req & ~dm_ack;
  assign dm_we    = dm_req & m_dmwe_q;
  assign dm_addr  = {m_o_q[31:2], 2'b00};
  assign dm_be    = dm_req ? al_be : 4'b0000;
  assign dm_wdata = dm_we ? al_wdata : 32'h0;

  always_comb begin
    m_o_d     = m_o_q;
    m_b_d     = m_b_q;
    m_insn_d  = m_insn_q;
    m_aluop_d = m_aluop_q;
    m_dmwe_d  = m_dmwe_q;
    m_rwe_d   = m_rwe_q;
    m_rdst_d  = m_rdst_q;
    m_rwd_d   = m_rwd_q;
    if (!stall) begin
      // A bubble is an all-zero M entry; opcode 0 is never a memory op.
      m_o_d     = x_valid ? x_o     : 32'h0;
      m_b_d     = x_valid ? x_b     : 32'h0;
      m_insn_d  = x_valid ? x_insn  : 32'h0;
      m_aluop_d = x_valid ? x_aluop : 6'h0;
      m_dmwe_d  = x_valid & x_dmwe;
      m_rwe_d   = x_valid & x_rwe;
      m_rdst_d  = x_valid & x_rdst;
      m_rwd_d   = x_valid & x_rwd;
    end
  end

  always_comb begin
    w_o_d     = 32'h0;
    w_d_d     = 32'h0;
    w_insn_d  = 32'h0;
    w_aluop_d = 6'h0;
    w_rwe_d   = 1'b0;
    w_rdst_d  = 1'b0;
    w_rwd_d   = 1'b0;
    w_mis_d   = 1'b0;
    if (!stall) begin
      w_o_d     = m_o_q;
      w_insn_d  = m_insn_q;
      w_aluop_d = m_aluop_q;
      w_rdst_d  = m_rdst_q;
      w_rwd_d   = m_rwd_q;
      if (m_misalign) begin
        w_mis_d = 1'b1;
      end else begin
        w_rwe_d = m_rwe_q;
        if (op_is_load(m_op)) w_d_d = al_ld;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      m_o_q     <= '0;
      m_b_q     <= '0;
      m_insn_q  <= '0;
      m_aluop_q <= '0;
      m_dmwe_q  <= 1'b0;
      m_rwe_q   <= 1'b0;
      m_rdst_q  <= 1'b0;
      m_rwd_q   <= 1'b0;
      w_o_q     <= '0;
      w_d_q     <= '0;
      w_insn_q  <= '0;
      w_aluop_q <= '0;
      w_rwe_q   <= 1'b0;
      w_rdst_q  <= 1'b0;
      w_rwd_q   <= 1'b0;
      w_mis_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_o_q     <= m_o_d;
      m_b_q     <= m_b_d;
      m_insn_q  <= m_insn_d;
      m_aluop_q <= m_aluop_d;
      m_dmwe_q  <= m_dmwe_d;
      m_rwe_q   <= m_rwe_d;
      m_rdst_q  <= m_rdst_d;
      m_rwd_q   <= m_rwd_d;
      w_o_q     <= w_o_d;
      w_d_q     <= w_d_d;
      w_insn_q  <= w_insn_d;
      w_aluop_q <= w_aluop_d;
      w_rwe_q   <= w_rwe_d;
      w_rdst_q  <= w_rdst_d;
      w_rwd_q   <= w_rwd_d;
      w_mis_q   <= w_mis_d;
    end
  end

  assign w_o        = w_o_q;
  assign w_d        = w_d_q;
  assign w_insn     = w_insn_q;
  assign w_aluop    = w_aluop_q;
  assign w_rwe      = w_rwe_q;
  assign w_rdst     = w_rdst_q;
  assign w_rwd      = w_rwd_q;
  assign w_misalign = w_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural reference model
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid = 1'b0;
  logic [31:0] x_o = '0, x_b = '0, x_insn = '0;
  logic [5:0]  x_aluop = '0;
  logic        x_dmwe = 1'b0, x_rwe = 1'b0, x_rdst = 1'b0, x_rwd = 1'b0;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic [31:0] w_o, w_d, w_insn;
  logic [5:0]  w_aluop;
  logic        w_rwe, w_rdst, w_rwd, w_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_o(x_o), .x_b(x_b),
    .x_insn(x_insn), .x_aluop(x_aluop), .x_dmwe(x_dmwe), .x_rwe(x_rwe),
    .x_rdst(x_rdst), .x_rwd(x_rwd), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .w_o(w_o), .w_d(w_d),
    .w_insn(w_insn), .w_aluop(w_aluop), .w_rwe(w_rwe), .w_rdst(w_rdst),
    .w_rwd(w_rwd), .w_misalign(w_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] o, b, insn;
    logic [5:0]  aluop;
    logic        dmwe, rwe, rdst, rwd;
  } m_t;

  typedef struct packed {
    logic [31:0] o, d, insn;
    logic [5:0]  aluop;
    logic        rwe, rdst, rwd, mis;
  } w_t;

  m_t mm = '0;
  w_t mw = '0;

  // Access width in bytes, 0 for anything that is not a load/store.
  function automatic int msize(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100100, 6'b101000: return 1;
      6'b100001, 6'b100101, 6'b101001: return 2;
      6'b100011, 6'b101011:            return 4;
      default:                         return 0;
    endcase
  endfunction

  function automatic bit mload(input logic [5:0] op);
    return op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
  endfunction

  function automatic bit msigned(input logic [5:0] op);
    return op inside {6'b100000, 6'b100001};
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] raw, input logic [31:0] a,
                                           input int sz, input bit sgn);
    int          sh;
    logic [31:0] mask, v;
    sh   = 8 * (4 - sz - int'(a[1:0]));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (raw >> sh) & mask;
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clock) begin
    logic [5:0]  op;
    int          sz;
    bit          req, mis, stl;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    w_t          nw;
    op  = mm.insn[31:26];
    sz  = msize(op);
    req = (sz != 0) && ((mm.o % sz) == 0);
    mis = (sz != 0) && !req;
    stl = req && !dm_ack;

    chk("dm_req", {31'b0, dm_req}, {31'b0, req});
    chk("stall", {31'b0, stall}, {31'b0, stl});
    chk("dm_addr", dm_addr, mm.o & 32'hFFFF_FFFC);
    if (req) begin
      ebe = 4'b0000;
      for (int i = 0; i < sz; i++) ebe[3 - (int'(mm.o[1:0]) + i)] = 1'b1;
      chk("dm_we", {31'b0, dm_we}, {31'b0, mm.dmwe});
      chk("dm_be", {28'b0, dm_be}, {28'b0, ebe});
      if (mm.dmwe) begin
        ewd = (sz == 1) ? {4{mm.b[7:0]}} : (sz == 2) ? {2{mm.b[15:0]}} : mm.b;
        chk("dm_wdata", dm_wdata, ewd);
      end
    end
    chk("w_o", w_o, mw.o);
    chk("w_d", w_d, mw.d);
    chk("w_insn", w_insn, mw.insn);
    chk("w_aluop", {26'b0, w_aluop}, {26'b0, mw.aluop});
    chk("w_ctl", {28'b0, w_rwe, w_rdst, w_rwd, w_misalign},
                 {28'b0, mw.rwe, mw.rdst, mw.rwd, mw.mis});

    if (reset) begin
      mm = '0;
      mw = '0;
    end else begin
      nw = '0;
      if (!stl) begin
        nw.o     = mm.o;
        nw.insn  = mm.insn;
        nw.aluop = mm.aluop;
        nw.rdst  = mm.rdst;
        nw.rwd   = mm.rwd;
        nw.mis   = mis;
        nw.rwe   = mis ? 1'b0 : mm.rwe;
        nw.d     = (!mis && mload(op)) ? load_val(dm_rdata, mm.o, sz, msigned(op)) : 32'h0;
        mm = x_valid ? '{o: x_o, b: x_b, insn: x_insn, aluop: x_aluop, dmwe: x_dmwe,
                         rwe: x_rwe, rdst: x_rdst, rwd: x_rwd} : '0;
      end
      mw = nw;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [31:0] insn, input logic [31:0] o, input logic [31:0] b,
                        input logic rwe, input logic dmwe, input logic rwd,
                        input int delay, input logic [31:0] rdata,
                        output int stalls, output logic req_s,
                        output logic [3:0] be_s, output logic [31:0] wd_s);
    x_valid = 1'b1; x_insn = insn; x_o = o; x_b = b; x_aluop = insn[5:0];
    x_dmwe = dmwe; x_rwe = rwe; x_rdst = 1'b1; x_rwd = rwd;
    dm_ack = 1'b0;
    @(posedge clock); #1;
    x_valid = 1'b0;
    stalls = 0;
    req_s  = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      if (stall) stalls++;
      if (dm_req) req_s = 1'b1;
      @(posedge clock); #1;
    end
    dm_ack = 1'b1; dm_rdata = rdata;
    @(negedge clock);
    if (stall) stalls++;
    if (dm_req) req_s = 1'b1;
    be_s = dm_be;
    wd_s = dm_wdata;
    @(posedge clock); #1;
    dm_ack = 1'b0;
  endtask

  initial begin
    int          st;
    logic        rq;
    logic [3:0]  be;
    logic [31:0] wd;

    // 1: reset with a stray ack
    dm_ack = 1'b1;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    chk("rst_req", {31'b0, dm_req}, 32'd0);
    chk("rst_outs", {dm_we, stall, w_rwe, w_rdst, w_rwd, w_misalign, dm_be} , 32'd0);
    chk("rst_w", w_o | w_d | w_insn | dm_wdata | dm_addr, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; dm_ack = 1'b0;

    // 2: ADD passes through in one cycle
    run_op(32'h0000_0020, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0, st, rq, be, wd);
    chk("add_w_o", w_o, 32'h0000_1234);
    chk("add_rwe", {31'b0, w_rwe}, 32'd1);
    chk("add_noreq", {31'b0, rq}, 32'd0);

    // 3: LB / LBU at 0x1001, ack three cycles late
    run_op(32'h8000_0000, 32'h0000_1001, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h11F0_2233, st, rq, be, wd);
    chk("lb_stalls", st, 32'd3);
    chk("lb_w_d", w_d, 32'hFFFF_FFF0);
    run_op(32'h9000_0000, 32'h0000_1001, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h11F0_2233, st, rq, be, wd);
    chk("lbu_w_d", w_d, 32'h0000_00F0);

    // Halfword loads, both lanes
    run_op(32'h8400_0000, 32'h0000_1002, 32'h0, 1'b1, 1'b0, 1'b1, 1, 32'h1234_ABCD, st, rq, be, wd);
    chk("lh_w_d", w_d, 32'hFFFF_ABCD);
    run_op(32'h9400_0000, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h8001_FFFF, st, rq, be, wd);
    chk("lhu_w_d", w_d, 32'h0000_8001);
    run_op(32'h8C00_0000, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 1'b1, 2, 32'hDEAD_BEEF, st, rq, be, wd);
    chk("lw_w_d", w_d, 32'hDEAD_BEEF);

    // 4: SH at 0x2002, immediate ack
    run_op(32'hA400_0000, 32'h0000_2002, 32'hABCD_1234, 1'b0, 1'b1, 1'b0, 0, 32'h0, st, rq, be, wd);
    chk("sh_stalls", st, 32'd0);
    chk("sh_be", {28'b0, be}, 32'h0000_0003);
    chk("sh_wdata", wd, 32'h1234_1234);
    run_op(32'hA000_0000, 32'h0000_4003, 32'h0000_005A, 1'b0, 1'b1, 1'b0, 0, 32'h0, st, rq, be, wd);
    chk("sb_be", {28'b0, be}, 32'h0000_0001);
    chk("sb_wdata", wd, 32'h5A5A_5A5A);
    run_op(32'hAC00_0000, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1, 32'h0, st, rq, be, wd);
    chk("sw_be", {28'b0, be}, 32'h0000_000F);
    chk("sw_wdata", wd, 32'hCAFE_F00D);

    // 5: misaligned LW
    run_op(32'h8C00_0000, 32'h0000_3001, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h5555_5555, st, rq, be, wd);
    chk("mis_noreq", {31'b0, rq}, 32'd0);
    chk("mis_pulse", {31'b0, w_misalign}, 32'd1);
    chk("mis_rwe", {31'b0, w_rwe}, 32'd0);
    @(posedge clock); #1;
    chk("mis_pulse_end", {31'b0, w_misalign}, 32'd0);

    // Back-to-back immediately-acked loads: a request every cycle
    dm_ack = 1'b1; dm_rdata = 32'h0102_0304;
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1; x_insn = 32'h8000_0000; x_o = 32'h0000_5000 + i; x_rwe = 1'b1;
      x_dmwe = 1'b0; x_aluop = 6'h0;
      @(posedge clock); #1;
    end
    x_valid = 1'b0;
    @(posedge clock); #1;
    dm_ack = 1'b0;
    chk("b2b_last_w_d", w_d, 32'h0000_0004);

    // 6: reset while waiting; a late ack must be ignored
    x_valid = 1'b1; x_insn = 32'h8C00_0000; x_o = 32'h0000_3004; x_rwe = 1'b1;
    @(posedge clock); #1;
    x_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("wait_req", {31'b0, dm_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_wait_req", {31'b0, dm_req}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
    @(posedge clock); #1;
    dm_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_w", w_o | w_d | w_insn, 32'd0);
    chk("late_ack_rwe", {31'b0, w_rwe}, 32'd0);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
